// File: rtl/fe_simple_tlb.sv
// fe_simple_tlb: fixed-content, fully associative instruction TLB for frontend
// stage F1. Translates the even and odd cache-line candidates every cycle.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   pc                  current fetch PC (reserved, no effect)
//   clc0_in, clc1_in    even / odd virtual line addresses
//   RW_in               0 = read/fetch, 1 = write
//   valid_in            request valid
//   pcd                 a hitting entry is uncacheable (MMIO)
//   hit                 both CLCs hit
//   exception           miss or permission fault on either CLC
//   exception_type      00 none, 01 miss, 10 permission fault
//   clcN_paddr          physical line address (low offset bits zero)
//   clcN_paddr_valid    per-CLC translation valid
// All outputs are registered (latency 1, one request per cycle).
module fe_simple_tlb #(
    parameter int XLEN      = 32,
    parameter int CLC_WIDTH = 28,
    parameter int ENTRIES   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      pc,
    input  logic [CLC_WIDTH-1:0] clc0_in,
    input  logic [CLC_WIDTH-1:0] clc1_in,
    input  logic                 RW_in,
    input  logic                 valid_in,
    output logic                 pcd,
    output logic                 hit,
    output logic                 exception,
    output logic [1:0]           exception_type,
    output logic [XLEN-1:0]      clc0_paddr,
    output logic [XLEN-1:0]      clc1_paddr,
    output logic                 clc0_paddr_valid,
    output logic                 clc1_paddr_valid
);

    localparam int VPN_W  = 20;
    localparam int LINE_W = CLC_WIDTH - VPN_W;
    localparam int OFF_W  = XLEN - CLC_WIDTH;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_MISS  = 2'b01;
    localparam logic [1:0] EXC_PERM  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [VPN_W-1:0] ppn;
        logic             r;
        logic             w;
        logic             x;
        logic             pcd;
    } entry_t;

    // Hard-wired boot mapping: low pages identity-mapped, one MMIO page,
    // one read-only code remap.
    function automatic entry_t boot_entry(input int idx);
        entry_t e;
        e = '0;
        if (idx < 6) begin
            e.valid = 1'b1;
            e.vpn   = VPN_W'(idx);
            e.ppn   = VPN_W'(idx);
            e.r     = 1'b1;
            e.w     = 1'b1;
            e.x     = 1'b1;
        end else if (idx == 6) begin
            e.valid = 1'b1;
            e.vpn   = 20'h10000;
            e.ppn   = 20'h10000;
            e.r     = 1'b1;
            e.w     = 1'b1;
            e.pcd   = 1'b1;
        end else if (idx == 7) begin
            e.valid = 1'b1;
            e.vpn   = 20'h00400;
            e.ppn   = 20'h00010;
            e.r     = 1'b1;
            e.x     = 1'b1;
        end
        return e;
    endfunction

    function automatic logic perm_ok(input entry_t e, input logic rw);
        return rw ? e.w : (e.r | e.x);
    endfunction

    // The pc port is reserved for future use.
    logic unused_pc;
    assign unused_pc = ^pc;

    entry_t tbl_q [ENTRIES];
    entry_t tbl_d [ENTRIES];

    logic            pcd_q, pcd_d;
    logic            hit_q, hit_d;
    logic            exc_q, exc_d;
    logic [1:0]      exc_type_q, exc_type_d;
    logic [XLEN-1:0] paddr0_q, paddr0_d;
    logic [XLEN-1:0] paddr1_q, paddr1_d;
    logic            pvalid0_q, pvalid0_d;
    logic            pvalid1_q, pvalid1_d;

    logic   hit0, hit1;
    logic   perm0, perm1;
    entry_t e0, e1;

    // No refill port: the table only changes on reset.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            tbl_d[i] = tbl_q[i];
        end
    end

    // Scan from the top so the lowest matching index is the last writer.
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        e0   = '0;
        e1   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tbl_q[i].valid &&
                tbl_q[i].vpn == clc0_in[CLC_WIDTH-1:LINE_W]) begin
                hit0 = 1'b1;
                e0   = tbl_q[i];
            end
            if (tbl_q[i].valid &&
                tbl_q[i].vpn == clc1_in[CLC_WIDTH-1:LINE_W]) begin
                hit1 = 1'b1;
                e1   = tbl_q[i];
            end
        end
        perm0 = hit0 & perm_ok(e0, RW_in);
        perm1 = hit1 & perm_ok(e1, RW_in);
    end

    always_comb begin
        pcd_d      = 1'b0;
        hit_d      = 1'b0;
        exc_d      = 1'b0;
        exc_type_d = EXC_NONE;
        paddr0_d   = '0;
        paddr1_d   = '0;
        pvalid0_d  = 1'b0;
        pvalid1_d  = 1'b0;
        if (valid_in) begin
            pvalid0_d = perm0;
            pvalid1_d = perm1;
            if (perm0) begin
                paddr0_d = {e0.ppn, clc0_in[LINE_W-1:0], {OFF_W{1'b0}}};
            end
            if (perm1) begin
                paddr1_d = {e1.ppn, clc1_in[LINE_W-1:0], {OFF_W{1'b0}}};
            end
            hit_d = hit0 & hit1;
            // e0/e1 are zero on a miss, so only hitting entries add PCD.
            pcd_d = e0.pcd | e1.pcd;
            exc_d = ~perm0 | ~perm1;
            // A miss outranks a permission fault.
            if (!hit0 || !hit1) begin
                exc_type_d = EXC_MISS;
            end else if (!perm0 || !perm1) begin
                exc_type_d = EXC_PERM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= boot_entry(i);
            end
            pcd_q      <= 1'b0;
            hit_q      <= 1'b0;
            exc_q      <= 1'b0;
            exc_type_q <= EXC_NONE;
            paddr0_q   <= '0;
            paddr1_q   <= '0;
            pvalid0_q  <= 1'b0;
            pvalid1_q  <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
            pcd_q      <= pcd_d;
            hit_q      <= hit_d;
            exc_q      <= exc_d;
            exc_type_q <= exc_type_d;
            paddr0_q   <= paddr0_d;
            paddr1_q   <= paddr1_d;
            pvalid0_q  <= pvalid0_d;
            pvalid1_q  <= pvalid1_d;
        end
    end

    assign pcd              = pcd_q;
    assign hit              = hit_q;
    assign exception        = exc_q;
    assign exception_type   = exc_type_q;
    assign clc0_paddr       = paddr0_q;
    assign clc1_paddr       = paddr1_q;
    assign clc0_paddr_valid = pvalid0_q;
    assign clc1_paddr_valid = pvalid1_q;

endmodule

// File: tb/tb_fe_simple_tlb.sv
// tb_fe_simple_tlb: scoreboard bench for fe_simple_tlb.
// Directed vectors push hand-computed results; a monitor pops and compares.
module tb_fe_simple_tlb;

    typedef struct packed {
        logic        pcd;
        logic        hit;
        logic        exc;
        logic [1:0]  etype;
        logic [31:0] p0;
        logic [31:0] p1;
        logic        v0;
        logic        v1;
    } out_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [27:0] clc0_in;
    logic [27:0] clc1_in;
    logic        RW_in;
    logic        valid_in;
    logic        pcd;
    logic        hit;
    logic        exception;
    logic [1:0]  exception_type;
    logic [31:0] clc0_paddr;
    logic [31:0] clc1_paddr;
    logic        clc0_paddr_valid;
    logic        clc1_paddr_valid;

    int errors = 0;
    int checks = 0;

    out_t  exp_q  [$];
    string name_q [$];

    fe_simple_tlb dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .clc0_in          (clc0_in),
        .clc1_in          (clc1_in),
        .RW_in            (RW_in),
        .valid_in         (valid_in),
        .pcd              (pcd),
        .hit              (hit),
        .exception        (exception),
        .exception_type   (exception_type),
        .clc0_paddr       (clc0_paddr),
        .clc1_paddr       (clc1_paddr),
        .clc0_paddr_valid (clc0_paddr_valid),
        .clc1_paddr_valid (clc1_paddr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t act();
        out_t o;
        o.pcd   = pcd;
        o.hit   = hit;
        o.exc   = exception;
        o.etype = exception_type;
        o.p0    = clc0_paddr;
        o.p1    = clc1_paddr;
        o.v0    = clc0_paddr_valid;
        o.v1    = clc1_paddr_valid;
        return o;
    endfunction

    function automatic out_t mk(input logic p, h, e, input logic [1:0] t,
                                input logic [31:0] a0, a1,
                                input logic v0, v1);
        out_t o;
        o.pcd = p; o.hit = h; o.exc = e; o.etype = t;
        o.p0 = a0; o.p1 = a1; o.v0 = v0; o.v1 = v1;
        return o;
    endfunction

    task automatic check(input string nm, input out_t a, input out_t x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got pcd=%b hit=%b exc=%b type=%b p0=%h p1=%h v0=%b v1=%b, expected pcd=%b hit=%b exc=%b type=%b p0=%h p1=%h v0=%b v1=%b",
                     nm, a.pcd, a.hit, a.exc, a.etype, a.p0, a.p1, a.v0, a.v1,
                     x.pcd, x.hit, x.exc, x.etype, x.p0, x.p1, x.v0, x.v1);
        end
    endtask

    task automatic drive(input string nm, input logic v, input logic rw,
                         input logic [27:0] c0, input logic [27:0] c1,
                         input out_t x);
        @(negedge clk);
        valid_in = v;
        RW_in    = rw;
        clc0_in  = c0;
        clc1_in  = c1;
        pc       = $urandom;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are registered, so after each rising edge the result
    // of the request driven on the previous falling edge is presented.
    always @(posedge clk) begin
        #1;
        if (rst && exp_q.size() > 0) begin
            out_t  x;
            string nm;
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, act(), x);
        end
    end

    initial begin
        out_t z;
        z        = '0;
        rst      = 1'b0;
        pc       = '0;
        clc0_in  = '0;
        clc1_in  = '0;
        RW_in    = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", act(), z);

        @(negedge clk);
        rst = 1'b1;

        drive("identity", 1, 0, 28'h0000010, 28'h0000011,
              mk(0, 1, 0, 2'b00, 32'h00000100, 32'h00000110, 1, 1));
        drive("remap_mmio", 1, 0, 28'h0040005, 28'h1000000,
              mk(1, 1, 0, 2'b00, 32'h00010050, 32'h10000000, 1, 1));
        drive("miss_clc1", 1, 0, 28'h0000010, 28'h0123400,
              mk(0, 0, 1, 2'b01, 32'h00000100, 32'h0, 1, 0));
        drive("perm_clc0", 1, 1, 28'h0040000, 28'h0000020,
              mk(0, 1, 1, 2'b10, 32'h0, 32'h00000200, 0, 1));
        drive("miss_over_perm", 1, 1, 28'h0040000, 28'h0123400,
              mk(0, 0, 1, 2'b01, 32'h0, 32'h0, 0, 0));
        drive("valid_low", 0, 0, 28'h0000010, 28'h1000000, z);
        drive("write_mmio", 1, 1, 28'h1000012, 28'h0000550,
              mk(1, 1, 0, 2'b00, 32'h10000120, 32'h00005500, 1, 1));
        drive("same_clc", 1, 0, 28'h0000234, 28'h0000234,
              mk(0, 1, 0, 2'b00, 32'h00002340, 32'h00002340, 1, 1));
        drive("perm_clc1", 1, 1, 28'h0000100, 28'h0040001,
              mk(0, 1, 1, 2'b10, 32'h00001000, 32'h0, 1, 0));
        drive("miss_edge_vpn6", 1, 0, 28'h00006FF, 28'h00005FF,
              mk(0, 0, 1, 2'b01, 32'h0, 32'h00005FF0, 0, 1));
        drive("mmio_with_miss", 1, 0, 28'h1000000, 28'h0000600,
              mk(1, 0, 1, 2'b01, 32'h10000000, 32'h0, 1, 0));
        drive("pre_async", 1, 0, 28'h0000010, 28'h0040005,
              mk(0, 1, 0, 2'b00, 32'h00000100, 32'h00010050, 1, 1));

        // Assert reset between edges while a valid result is showing.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset", act(), z);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", act(), z);

        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b0;
        exp_q.push_back(z);
        name_q.push_back("post_reset_idle");
        drive("post_reset_first", 1, 0, 28'h0000345, 28'h1000001,
              mk(1, 1, 0, 2'b00, 32'h00003450, 32'h10000010, 1, 1));
        @(negedge clk);
        valid_in = 1'b0;

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
